tlb_ptw: RTL

Sv39 hardware page-table walker that sits directly upstream of the TLB entry array in the BIU. On a TLB miss it reads up to three PTEs from memory, checks them, and produces the complete fill bundle (VPN, 4 KiB-granular PPN, PTE, PTE physical address) together with a one-cycle write strobe for the victim entry. Invalid or malformed translations are reported as a walk fault instead.

---
 rtl/tlb_ptw.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/tlb_ptw.sv
// tlb_ptw: Sv39 page-table walker producing a 4 KiB-granular TLB fill bundle or a walk fault
//   walk_req/walk_vpn/satp_ppn/walk_abort : walk control from the TLB miss logic
//   mem_rd/mem_addr/mem_rdata/mem_rdy     : single-beat PTE read port
//   tlb_write/vpn_out/ppn_out/pte_out/pte_pa_out : fill bundle for the victim entry
//   busy/walk_done/walk_fault             : walk status, all registered
module tlb_ptw (
  input  logic        clk,
  input  logic        rst,
  input  logic        walk_req,
  input  logic [26:0] walk_vpn,
  input  logic [43:0] satp_ppn,
  input  logic        walk_abort,
  output logic        busy,
  output logic        mem_rd,
  output logic [63:0] mem_addr,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rdy,
  output logic        tlb_write,
  output logic [26:0] vpn_out,
  output logic [43:0] ppn_out,
  output logic [63:0] pte_out,
  output logic [63:0] pte_pa_out,
  output logic        walk_done,
  output logic        walk_fault
);
  typedef enum logic [2:0] {IDLE, READ, EVAL, FILL, FAULT} state_t;
  state_t state_q, state_d, eval_nxt;
  logic [1:0]  level_q, level_d;
  logic        abort_pend_q, abort_pend_d;
  logic [26:0] vpn_q, vpn_d;
  logic [43:0] a_ppn_q, a_ppn_d;
  logic [63:0] pte_q, pte_d, pte_pa_q, pte_pa_d;
  logic        busy_q, busy_d, mem_rd_q, mem_rd_d, tlb_write_q, tlb_write_d;
  logic        walk_done_q, walk_done_d, walk_fault_q, walk_fault_d;
  logic [63:0] mem_addr_q, mem_addr_d, pte_out_q, pte_out_d, pte_pa_out_q, pte_pa_out_d;
  logic [26:0] vpn_out_q, vpn_out_d;
  logic [43:0] ppn_out_q, ppn_out_d, fill_ppn;
  logic [8:0]  vidx;
  logic        bad, ptr, misal;
  assign bad   = !pte_q[0] || (!pte_q[1] && pte_q[2]);
  assign ptr   = !pte_q[1] && !pte_q[3];
  assign misal = level_q == 2'd2 ? |pte_q[27:10] : level_q == 2'd1 ? |pte_q[18:10] : 1'b0;
  assign eval_nxt = bad ? FAULT : ptr ? (level_q == 2'd0 ? FAULT : READ) : (!pte_q[6] || misal) ? FAULT : FILL;
  // superpages are split: low 9*level PPN bits come from the VPN so every fill is a 4 KiB mapping
  assign fill_ppn = level_q == 2'd2 ? {pte_q[53:28], vpn_q[17:0]} :
                    level_q == 2'd1 ? {pte_q[53:19], vpn_q[8:0]} : pte_q[53:10];
  assign vidx = level_d == 2'd2 ? vpn_d[26:18] : level_d == 2'd1 ? vpn_d[17:9] : vpn_d[8:0];
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    abort_pend_d = abort_pend_q;
    vpn_d        = vpn_q;
    a_ppn_d      = a_ppn_q;
    pte_d        = pte_q;
    pte_pa_d     = pte_pa_q;
    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (walk_req) begin
          state_d = READ;
          vpn_d   = walk_vpn;
          level_d = 2'd2;
          a_ppn_d = satp_ppn;
        end
      end
      READ: begin
        // an accepted read cannot be withdrawn, so an abort waits for mem_rdy
        abort_pend_d = abort_pend_q | walk_abort;
        if (mem_rdy) begin
          pte_d    = mem_rdata;
          pte_pa_d = mem_addr_q;
          state_d  = abort_pend_d ? IDLE : EVAL;
        end
      end
      EVAL: begin
        state_d = walk_abort ? IDLE : eval_nxt;
        if (eval_nxt == READ) begin
          a_ppn_d = pte_q[53:10];
          level_d = level_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy_d       = state_d != IDLE;
  assign mem_rd_d     = state_d == READ;
  assign tlb_write_d  = state_d == FILL;
  assign walk_done_d  = state_d == FILL || state_d == FAULT;
  assign walk_fault_d = state_d == FAULT;
  assign mem_addr_d   = state_d == READ ? {8'b0, a_ppn_d, vidx, 3'b0} : mem_addr_q;
  assign ppn_out_d    = state_d == FILL ? fill_ppn : ppn_out_q;
  assign vpn_out_d    = state_d == FILL ? vpn_q : vpn_out_q;
  assign pte_out_d    = state_d == FILL ? pte_q : pte_out_q;
  assign pte_pa_out_d = state_d == FILL ? pte_pa_q : pte_pa_out_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      level_q      <= 2'd0;
      abort_pend_q <= 1'b0;
      vpn_q        <= '0;
      a_ppn_q      <= '0;
      pte_q        <= '0;
      pte_pa_q     <= '0;
      busy_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      tlb_write_q  <= 1'b0;
      walk_done_q  <= 1'b0;
      walk_fault_q <= 1'b0;
      mem_addr_q   <= '0;
      ppn_out_q    <= '0;
      vpn_out_q    <= '0;
      pte_out_q    <= '0;
      pte_pa_out_q <= '0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      abort_pend_q <= abort_pend_d;
      vpn_q        <= vpn_d;
      a_ppn_q      <= a_ppn_d;
      pte_q        <= pte_d;
      pte_pa_q     <= pte_pa_d;
      busy_q       <= busy_d;
      mem_rd_q     <= mem_rd_d;
      tlb_write_q  <= tlb_write_d;
      walk_done_q  <= walk_done_d;
      walk_fault_q <= walk_fault_d;
      mem_addr_q   <= mem_addr_d;
      ppn_out_q    <= ppn_out_d;
      vpn_out_q    <= vpn_out_d;
      pte_out_q    <= pte_out_d;
      pte_pa_out_q <= pte_pa_out_d;
    end
  end
  assign busy       = busy_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign tlb_write  = tlb_write_q;
  assign walk_done  = walk_done_q;
  assign walk_fault = walk_fault_q;
  assign vpn_out    = vpn_out_q;
  assign ppn_out    = ppn_out_q;
  assign pte_out    = pte_out_q;
  assign pte_pa_out = pte_pa_out_q;
endmodule
